reaction_controller: RTL

Trial-sequencing FSM for the reaction timer; sits directly upstream of the 4-digit BCD counter. Arms on a Start press, waits a pseudo-random delay, lights the stimulus, and then issues one count-enable pulse per millisecond until the Response press. It also flags false starts and timeouts and holds the result for display.

---
 rtl/reaction_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/reaction_controller.sv
// Reaction-timer trial sequencer: arms on Start, waits a pseudo-random delay, lights
// the stimulus, then pulses CountEn once per ms until Response. Option: `FALSE_START_EN.
module reaction_controller #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_REACT_MS = 9999
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic Response,
  output logic CountClr,
  output logic CountEn,
  output logic Stimulus,
  output logic Done,
  output logic Timeout,
  output logic FalseStart
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    TIMING = 3'd2,
    RESULT = 3'd3
`ifdef FALSE_START_EN
    , FAULT = 3'd4
`endif
  } state_t;

  state_t        state_q, state_d;
  logic          start_prev_q, resp_prev_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   elapsed_q, elapsed_d, elapsed_inc;
  logic [15:0]   delay_q, delay_d;
  logic          count_clr_q, count_clr_d;
  logic          count_en_q, count_en_d;
  logic          stimulus_q, stimulus_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          start_ev, resp_ev, tick;
`ifdef FALSE_START_EN
  logic          false_start_q, false_start_d;
`endif

  assign start_ev = Start & ~start_prev_q;
  assign resp_ev  = Response & ~resp_prev_q;
  assign tick     = (presc_q == PW'(CLKS_PER_MS - 1));

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    elapsed_d   = elapsed_q;
    delay_d     = delay_q;
    count_clr_d = 1'b0;
    count_en_d  = 1'b0;
    timeout_d   = timeout_q;
    elapsed_inc = elapsed_q + 14'd1;
    // Fibonacci form, taps 16/14/13/11: a nonzero seed never reaches zero
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (state_q)
      IDLE: begin
        if (start_ev) state_d = ARMED;
      end
      ARMED: begin
        if (tick) elapsed_d = elapsed_inc;
        if (tick && ({2'b00, elapsed_inc} == delay_q)) state_d = TIMING;
`ifdef FALSE_START_EN
        // A press coinciding with delay expiry still counts as a false start
        if (resp_ev) state_d = FAULT;
`endif
      end
      TIMING: begin
        if (tick) begin
          count_en_d = 1'b1;
          elapsed_d  = elapsed_inc;
          if (elapsed_inc == 14'(MAX_REACT_MS)) begin
            state_d   = RESULT;
            timeout_d = 1'b1;
          end
        end
        if (resp_ev) state_d = RESULT;
      end
      RESULT: begin
        if (start_ev) state_d = ARMED;
      end
`ifdef FALSE_START_EN
      FAULT: begin
        if (start_ev) state_d = ARMED;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Both timed states start from a fresh ms boundary
    if ((state_d == ARMED || state_d == TIMING) && (state_d != state_q)) begin
      presc_d   = '0;
      elapsed_d = '0;
    end else if (state_q == ARMED || state_q == TIMING) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (state_d == ARMED && state_q != ARMED) begin
      count_clr_d = 1'b1;
      timeout_d   = 1'b0;
      delay_d     = 16'(MIN_DELAY_MS) + {5'b00000, lfsr_q[10:0]};
    end

    stimulus_d = (state_d == TIMING);
    done_d     = (state_d == RESULT);
`ifdef FALSE_START_EN
    false_start_d = (state_d == FAULT);
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      resp_prev_q  <= 1'b0;
      lfsr_q       <= 16'hACE1;
      presc_q      <= '0;
      elapsed_q    <= '0;
      delay_q      <= '0;
      count_clr_q  <= 1'b0;
      count_en_q   <= 1'b0;
      stimulus_q   <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef FALSE_START_EN
      false_start_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= Start;
      resp_prev_q  <= Response;
      lfsr_q       <= lfsr_d;
      presc_q      <= presc_d;
      elapsed_q    <= elapsed_d;
      delay_q      <= delay_d;
      count_clr_q  <= count_clr_d;
      count_en_q   <= count_en_d;
      stimulus_q   <= stimulus_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
`ifdef FALSE_START_EN
      false_start_q <= false_start_d;
`endif
    end
  end

  assign CountClr = count_clr_q;
  assign CountEn  = count_en_q;
  assign Stimulus = stimulus_q;
  assign Done     = done_q;
  assign Timeout  = timeout_q;
`ifdef FALSE_START_EN
  assign FalseStart = false_start_q;
`else
  assign FalseStart = 1'b0;
`endif

endmodule
